// File: rtl/seven_scan_driver_if.sv
// seven_scan_driver_if: datapath-side controls and display-pin outputs of seven_scan_driver.
interface seven_scan_driver_if #(parameter int DIGITS = 8);
   logic                en;
   logic                load;
   logic [4*DIGITS-1:0] nums;
   logic [DIGITS-1:0]   dp_mask;
   logic [DIGITS-1:0]   blank_mask;
   logic [DIGITS-1:0]   digit_sel;
   logic [7:0]          digit_show;
   logic                frame_tick;
   modport master (output en, load, nums, dp_mask, blank_mask, input digit_sel, digit_show, frame_tick);
   modport slave  (input en, load, nums, dp_mask, blank_mask, output digit_sel, digit_show, frame_tick);
endinterface

// File: rtl/seven_scan_driver.sv
// seven_scan_driver: double-buffered multiplexed common-anode seven-segment scanner.
// Define SEVSEG_HEX_EN to render codes 10..15 as A b C d E F; otherwise they are dark.
module seven_scan_driver #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000
) (
   input logic                clk,
   input logic                rst_n,
   seven_scan_driver_if.slave bus
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

   logic [4*DIGITS-1:0] r_sh_nums, r_nums;
   logic [DIGITS-1:0]   r_sh_dp, r_dp, r_sh_blank, r_blank, r_sel;
   logic [PW-1:0]       r_pcnt;
   logic [IW-1:0]       r_idx;
   logic                r_run, r_tick;
   logic [7:0]          r_show;
   logic [3:0]          w_code;
   logic [6:0]          w_seg;
   logic [7:0]          w_show;
   logic                w_pwrap, w_last, w_fstart;

   assign w_pwrap  = r_pcnt == PMAX;
   assign w_last   = r_idx == LAST;
   // r_run low marks the first enabled cycle after reset or re-enable, which opens a fresh frame
   assign w_fstart = bus.en & (~r_run | (w_pwrap & w_last));

   always_comb begin
      w_code = r_nums[{r_idx, 2'b00} +: 4];
      case (w_code)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
`ifdef SEVSEG_HEX_EN
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
`endif
         default: w_seg = 7'h7F;
      endcase
      w_show = r_blank[r_idx] ? 8'hFF : {~r_dp[r_idx], w_seg};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sh_nums  <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '1;
         r_nums     <= '0;
         r_dp       <= '0;
         r_blank    <= '1;
         r_pcnt     <= '0;
         r_idx      <= '0;
         r_run      <= 1'b0;
         r_sel      <= '1;
         r_show     <= 8'hFF;
         r_tick     <= 1'b0;
      end else begin
         if (bus.load) begin
            r_sh_nums  <= bus.nums;
            r_sh_dp    <= bus.dp_mask;
            r_sh_blank <= bus.blank_mask;
         end
         // a load landing on the frame start bypasses the shadow so it shows in this frame
         if (w_fstart) begin
            r_nums  <= bus.load ? bus.nums       : r_sh_nums;
            r_dp    <= bus.load ? bus.dp_mask    : r_sh_dp;
            r_blank <= bus.load ? bus.blank_mask : r_sh_blank;
         end
         r_tick <= w_fstart;
         if (!bus.en) begin
            r_run  <= 1'b0;
            r_pcnt <= '0;
            r_idx  <= '0;
            r_sel  <= '1;
            r_show <= 8'hFF;
         end else begin
            r_run  <= 1'b1;
            r_sel  <= r_run ? ~(DIGITS'(1) << r_idx) : '1;
            r_show <= r_run ? w_show : 8'hFF;
            if (r_run) begin
               r_pcnt <= w_pwrap ? '0 : r_pcnt + PW'(1);
               if (w_pwrap) r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
         end
      end
   end

   assign bus.digit_sel  = r_sel;
   assign bus.digit_show = r_show;
   assign bus.frame_tick = r_tick;
endmodule
